// File: rtl/seq_pkg.sv
// Shared types and helpers for the CNN layer sequencer: FSM state encoding,
// default widths and small arithmetic/indexing helpers for the flattened buses.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam int DEF_NUM_LAYERS = 4;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_TO_W       = 24;
  localparam int CNT_W          = 32;

  // Low bit of engine idx's field inside a flattened NUM_LAYERS*width bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_port_mux.sv
// Routes the active engine's feature-map RAM ports onto the single shared RAM
// interface; everything is forced to zero when no engine holds the grant.
module ram_port_mux
  import seq_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                         grant_i,
  input  logic [NUM_LAYERS-1:0]        sel_oh_i,
  input  logic [NUM_LAYERS*ADDR_W-1:0] eng_addr_w_i,
  input  logic [NUM_LAYERS*DATA_W-1:0] eng_data_w_i,
  input  logic [NUM_LAYERS-1:0]        eng_en_i,
  input  logic [NUM_LAYERS-1:0]        eng_wea_i,
  input  logic [NUM_LAYERS*ADDR_W-1:0] eng_addr_r_i,
  input  logic [NUM_LAYERS-1:0]        eng_en_r_i,
  output logic [ADDR_W-1:0]            ram_addr_w_o,
  output logic [DATA_W-1:0]            ram_data_w_o,
  output logic                         ram_en_o,
  output logic                         ram_wea_o,
  output logic [ADDR_W-1:0]            ram_addr_r_o,
  output logic                         ram_en_r_o
);

  logic [ADDR_W-1:0] addr_w_arr [NUM_LAYERS];
  logic [DATA_W-1:0] data_w_arr [NUM_LAYERS];
  logic [ADDR_W-1:0] addr_r_arr [NUM_LAYERS];

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_unpack
    assign addr_w_arr[gi] = eng_addr_w_i[slice_lo(gi, ADDR_W) +: ADDR_W];
    assign data_w_arr[gi] = eng_data_w_i[slice_lo(gi, DATA_W) +: DATA_W];
    assign addr_r_arr[gi] = eng_addr_r_i[slice_lo(gi, ADDR_W) +: ADDR_W];
  end

  // sel_oh_i is one-hot, so at most one iteration drives the outputs.
  always_comb begin
    ram_addr_w_o = '0;
    ram_data_w_o = '0;
    ram_en_o     = 1'b0;
    ram_wea_o    = 1'b0;
    ram_addr_r_o = '0;
    ram_en_r_o   = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (grant_i && sel_oh_i[i]) begin
        ram_addr_w_o = addr_w_arr[i];
        ram_data_w_o = data_w_arr[i];
        ram_en_o     = eng_en_i[i];
        ram_wea_o    = eng_wea_i[i];
        ram_addr_r_o = addr_r_arr[i];
        ram_en_r_o   = eng_en_r_i[i];
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// PL scheduler for the CNN accelerator: runs the enabled conv engines in index
// order, owns the shared feature-map RAM grant and reports status to the PS.
module layer_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TO_W       = DEF_TO_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ps_start,
  input  logic [NUM_LAYERS-1:0]        layer_mask,
  input  logic [TO_W-1:0]              timeout_limit,
  output logic                         busy,
  output logic                         ps_done,
  output logic                         err_timeout,
  output logic [2:0]                   cur_layer,
  output logic [31:0]                  layer_cycles,
  output logic [31:0]                  total_cycles,
  output logic [NUM_LAYERS-1:0]        eng_start,
  input  logic [NUM_LAYERS-1:0]        eng_end,
  input  logic [NUM_LAYERS*ADDR_W-1:0] eng_ram_addr_w,
  input  logic [NUM_LAYERS*DATA_W-1:0] eng_ram_data_w,
  input  logic [NUM_LAYERS-1:0]        eng_ram_en,
  input  logic [NUM_LAYERS-1:0]        eng_ram_wea,
  input  logic [NUM_LAYERS*ADDR_W-1:0] eng_ram_addr_r,
  input  logic [NUM_LAYERS-1:0]        eng_ram_en_r,
  output logic [ADDR_W-1:0]            ram_addr_w,
  output logic [DATA_W-1:0]            ram_data_w,
  output logic                         ram_en,
  output logic                         ram_wea,
  output logic [ADDR_W-1:0]            ram_addr_r,
  output logic                         ram_en_r
);

  localparam int IDX_W = $clog2(NUM_LAYERS + 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_LAYERS-1:0]   mask_q;
  logic [TO_W-1:0]         limit_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;
  logic                    ps_done_q;
  logic                    err_q;
  logic [2:0]              cur_layer_q;
  logic [CNT_W-1:0]        layer_cycles_q;
  logic [CNT_W-1:0]        total_q;
  logic [NUM_LAYERS-1:0]   eng_start_q;

  logic [NUM_LAYERS-1:0]   sel_oh;
  logic                    mask_hit;
  logic                    end_hit;
  logic                    grant;
  logic                    wd_expired;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_sel
    assign sel_oh[gi] = (idx_q == IDX_W'(gi));
  end

  assign mask_hit = |(mask_q & sel_oh);
  assign end_hit  = |(eng_end & sel_oh);
  assign grant    = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);
  // Fires on the cycle whose closing edge brings the layer counter up to the limit.
  assign wd_expired = (limit_q != '0) &&
                      (({1'b0, cnt_q} + 33'd1) >= 33'(limit_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      mask_q         <= '0;
      limit_q        <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      ps_done_q      <= 1'b0;
      err_q          <= 1'b0;
      cur_layer_q    <= '0;
      layer_cycles_q <= '0;
      total_q        <= '0;
      eng_start_q    <= '0;
    end else begin
      eng_start_q <= '0;
      ps_done_q   <= 1'b0;
      if (state_q != S_IDLE) begin
        total_q <= sat_inc(total_q);
      end
      case (state_q)
        S_IDLE: begin
          if (ps_start) begin
            mask_q  <= layer_mask;
            limit_q <= timeout_limit;
            err_q   <= 1'b0;
            total_q <= 32'd1;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (idx_q == IDX_W'(NUM_LAYERS)) begin
            busy_q    <= 1'b0;
            ps_done_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (mask_hit) begin
            cur_layer_q <= 3'(idx_q);
            eng_start_q <= sel_oh;
            state_q     <= S_START;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_START: begin
          cnt_q   <= 32'd1;
          state_q <= S_RUN;
        end
        S_RUN, S_DRAIN: begin
          // The watchdog outranks a coincident end or end release.
          if (wd_expired) begin
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            ps_done_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= sat_inc(cnt_q);
            if (state_q == S_RUN) begin
              if (end_hit) begin
                layer_cycles_q <= cnt_q;
                state_q        <= S_DRAIN;
              end
            end else if (!end_hit) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_SELECT;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign ps_done      = ps_done_q;
  assign err_timeout  = err_q;
  assign cur_layer    = cur_layer_q;
  assign layer_cycles = layer_cycles_q;
  assign total_cycles = total_q;
  assign eng_start    = eng_start_q;

  ram_port_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) u_ram_port_mux (
    .grant_i      (grant),
    .sel_oh_i     (sel_oh),
    .eng_addr_w_i (eng_ram_addr_w),
    .eng_data_w_i (eng_ram_data_w),
    .eng_en_i     (eng_ram_en),
    .eng_wea_i    (eng_ram_wea),
    .eng_addr_r_i (eng_ram_addr_r),
    .eng_en_r_i   (eng_ram_en_r),
    .ram_addr_w_o (ram_addr_w),
    .ram_data_w_o (ram_data_w),
    .ram_en_o     (ram_en),
    .ram_wea_o    (ram_wea),
    .ram_addr_r_o (ram_addr_r),
    .ram_en_r_o   (ram_en_r)
  );

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level PL scheduler for the CNN accelerator.
- On a PS start pulse it runs the conv layer engines (ConV1..ConVN) strictly in order, skipping masked layers.
- Each engine gets a one-cycle start; the sequencer waits for that engine's level-type end signal.
- While an engine is active, its feature-map RAM read/write ports are granted onto the single shared RAM interface.
- Reports done, a timeout error and cycle counts back to the PS.

Parameters:
NUM_LAYERS, 4, number of engines sequenced; index 0 runs first.
ADDR_W, 16, RAM address width.
DATA_W, 8, RAM data width.
TO_W, 24, timeout limit width.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
ps_start  in  1  run request pulse; ignored while busy.
layer_mask  in  NUM_LAYERS  bit i=1 enables layer i; sampled on ps_start acceptance.
timeout_limit  in  TO_W  per-layer cycle limit; 0 disables the watchdog; sampled on acceptance.
busy  out  1  high from acceptance until the done pulse.
ps_done  out  1  one-cycle completion pulse.
err_timeout  out  1  sticky; cleared on the next accepted ps_start.
cur_layer  out  3  index of the active or last layer.
layer_cycles  out  32  START-to-end cycles of the most recently finished layer.
total_cycles  out  32  cycles from acceptance to ps_done; saturates at 0xFFFFFFFF.
eng_start  out  NUM_LAYERS  one-hot, one-cycle start pulse.
eng_end  in  NUM_LAYERS  engine end level; may stay high for several cycles.
eng_ram_addr_w  in  NUM_LAYERS*ADDR_W  flattened; slice i belongs to engine i.
eng_ram_data_w  in  NUM_LAYERS*DATA_W  flattened.
eng_ram_en  in  NUM_LAYERS  write-port enable per engine.
eng_ram_wea  in  NUM_LAYERS  write strobe per engine.
eng_ram_addr_r  in  NUM_LAYERS*ADDR_W  flattened.
eng_ram_en_r  in  NUM_LAYERS  read-port enable per engine.
ram_addr_w, ram_data_w, ram_en, ram_wea  out  ADDR_W/DATA_W/1/1  shared write port.
ram_addr_r, ram_en_r  out  ADDR_W/1  shared read port; read data is broadcast to engines outside this block.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- FSM states: IDLE, SELECT, START, RUN, DRAIN, DONE.
- IDLE:
  - On ps_start, latch mask and limit, clear err_timeout and total_cycles, set busy, set idx=0.
  - Go to SELECT.
- SELECT (one cycle per layer index examined):
  - If idx==NUM_LAYERS, go to DONE.
  - Else if mask[idx]=1, set cur_layer=idx and go to START.
  - Else idx++ and stay in SELECT.
- START:
  - eng_start[idx]=1 for exactly this cycle.
  - Clear the layer counter; go to RUN.
- RUN:
  - Layer counter increments every cycle.
  - When eng_end[idx]=1, latch layer_cycles and go to DRAIN.
  - eng_end of any non-active engine is ignored.
- DRAIN:
  - Wait for eng_end[idx]=0, so a held end level is never counted twice.
  - Then idx++ and go to SELECT.
- Watchdog:
  - In RUN or DRAIN, if limit≠0 and the layer counter reaches the limit, set err_timeout.
  - Abandon the remaining layers and go to DONE. No further eng_start is issued.
- DONE: ps_done=1 for one cycle, busy falls in the same cycle, go to IDLE.
- total_cycles increments every cycle while busy (including DONE) and saturates.
- RAM mux (purely combinational, zero added latency):
  - Grant is valid in START, RUN and DRAIN and selects the engine slice at idx.
  - When no grant: ram_en, ram_wea and ram_en_r are forced to 0, and address/data are 0.
  - Non-granted engines' requests are dropped; engines must only touch RAM while active.
- ps_start while busy: no effect.
- All-zero mask: no starts; ps_done occurs NUM_LAYERS+2 cycles after acceptance.
- rst mid-run: immediate return to IDLE with all outputs 0. Engines are reset externally by the same rst.

Decomposition:
- Package seq_pkg holds:
  - state encoding constants (IDLE..DONE);
  - default widths;
  - a slice-index helper function for the flattened buses.
- One sub-module is natural: ram_port_mux (combinational grant/slice mux, parameterised on NUM_LAYERS, ADDR_W and DATA_W).

Test Plan:
- mask=4'b1111, limit=0, engine model asserts end 50 cycles after start and holds it 4 cycles -> eng_start pulses 0,1,2,3 each exactly once; layer_cycles=50; one ps_done; err_timeout=0.
- mask=4'b0101 -> only eng_start[0] and eng_start[2] pulse; cur_layer ends at 2; RAM outputs are never driven by engines 1 or 3.
- mask=4'b0000, ps_start at cycle 10 -> ps_done at cycle 16; no eng_start; total_cycles=7.
- limit=100, engine 1 never ends -> err_timeout=1 and ps_done 100 cycles after START of layer 1; eng_start[2] and eng_start[3] never pulse; next ps_start clears err_timeout.
- During layer 2, engine 2 drives write addr 0x8123/data 0x7F/en=1/wea=1 while engine 0 drives en=1 -> ram_addr_w=0x8123, ram_data_w=0x7F in the same cycle; in IDLE ram_en=ram_wea=ram_en_r=0.
- ps_start pulsed again mid-run, then rst asserted in RUN -> the second start is ignored; one cycle after rst, busy=0, eng_start=0 and all outputs are 0.
